// File: rtl/joy_dir_filter.sv
// joy_dir_filter: per-player joystick direction conditioner.
// The raw directions are synchronised and debounced. A runtime-selected policy
// (pass, 4-way last-pressed, 4-way first-held, 8-way SOCD cancel) is then
// applied, and each player gets a change strobe.
//
// Output strobe semantics: dir_chg[p] is high for exactly one clk, on the
// same edge that outdir[4p+3:4p] takes a new value. There is no back-pressure;
// a consumer that needs the change samples it on that clk.
module joy_dir_filter #(
  parameter int NUM_PLAYERS = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [1:0]               mode,
  input  logic [4*NUM_PLAYERS-1:0] indir,
  output logic [4*NUM_PLAYERS-1:0] outdir,
  output logic [NUM_PLAYERS-1:0]   dir_chg,
  output logic [3*NUM_PLAYERS-1:0] dbg_sel
);

  localparam int NB = 4 * NUM_PLAYERS;

  // Selection state for the 4-way policies; exported on dbg_sel per player.
  typedef enum logic [2:0] {
    SEL_IDLE  = 3'd0,
    SEL_UP    = 3'd1,
    SEL_DOWN  = 3'd2,
    SEL_LEFT  = 3'd3,
    SEL_RIGHT = 3'd4
  } sel_t;

  // Fixed priority up > down > left > right; bit order is {up,down,left,right}.
  function automatic sel_t pick_dir(input logic [3:0] v);
    if (v[3])      return SEL_UP;
    else if (v[2]) return SEL_DOWN;
    else if (v[1]) return SEL_LEFT;
    else if (v[0]) return SEL_RIGHT;
    else           return SEL_IDLE;
  endfunction

  function automatic logic [3:0] dir_onehot(input sel_t s);
    case (s)
      SEL_UP:    return 4'b1000;
      SEL_DOWN:  return 4'b0100;
      SEL_LEFT:  return 4'b0010;
      SEL_RIGHT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic is_held(input sel_t s, input logic [3:0] v);
    return |(dir_onehot(s) & v);
  endfunction

  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] db;
  logic [1:0]    mode_q;
  logic          mode_chg;

  // Two-flop synchroniser, runs every clk independent of ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= indir;
      sync2_q <= sync1_q;
    end
  end

  // Remember last mode so a mode switch can clear all players for one edge.
  always_ff @(posedge clk) begin
    if (reset) mode_q <= 2'd0;
    else       mode_q <= mode;
  end

  assign mode_chg = (mode != mode_q);

  generate
    if (DEBOUNCE == 0) begin : g_nodb
      assign db = sync2_q;
    end else begin : g_db
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
      for (genvar b = 0; b < NB; b++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;

        // Per-bit debounce: DEBOUNCE consecutive differing ce samples flip the bit.
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
          end else if (ce) begin
            if (sync2_q[b] == db_q) begin
              cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
              db_q  <= sync2_q[b];
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        assign db[b] = db_q;
      end
    end
  endgenerate

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0] db_p;
    logic [3:0] prev_q;
    logic [3:0] rise;
    logic [3:0] out_q;
    logic [3:0] out_next;
    logic       chg_q;
    sel_t       sel_q;
    sel_t       sel_next;

    assign db_p = db[4*p +: 4];
    assign rise = db_p & ~prev_q;

    // Next selection and output for this player under the current policy.
    always_comb begin
      sel_next = sel_q;
      out_next = 4'b0000;
      if (mode_chg) begin
        sel_next = SEL_IDLE;
      end else begin
        case (mode)
          2'd0: begin
            sel_next = SEL_IDLE;
            out_next = db_p;
          end
          2'd1: begin
            if (|rise)
              sel_next = pick_dir(rise);
            else if (sel_q != SEL_IDLE && !is_held(sel_q, db_p))
              sel_next = pick_dir(db_p);
            out_next = dir_onehot(sel_next);
          end
          2'd2: begin
            // IDLE is never "held", so this also covers the IDLE->SEL entry.
            if (!is_held(sel_q, db_p))
              sel_next = pick_dir(db_p);
            out_next = dir_onehot(sel_next);
          end
          default: begin
            sel_next = SEL_IDLE;
            out_next = db_p;
            if (db_p[3] && db_p[2]) out_next[3:2] = 2'b00;
            if (db_p[1] && db_p[0]) out_next[1:0] = 2'b00;
          end
        endcase
      end
    end

    // Register selection, previous debounced bits, output and change strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        sel_q  <= SEL_IDLE;
        prev_q <= 4'b0000;
        out_q  <= 4'b0000;
        chg_q  <= 1'b0;
      end else begin
        sel_q  <= sel_next;
        prev_q <= db_p;
        out_q  <= out_next;
        chg_q  <= (out_next != out_q);
      end
    end

    assign outdir[4*p +: 4]  = out_q;
    assign dir_chg[p]        = chg_q;
    assign dbg_sel[3*p +: 3] = sel_q;
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Testbench for joy_dir_filter (2 players, DEBOUNCE=4, ce tied high).
// Stimulus pushes expected {edge, dir_chg, outdir} events; a monitor pops them
// whenever dir_chg pulses and also flags events that never arrived.
module tb_joy_dir_filter;

  localparam int EW = 26;  // {edge[15:0], dir_chg[1:0], outdir[7:0]}

  logic       clk;
  logic       reset;
  logic       ce;
  logic [1:0] mode;
  logic [7:0] indir;
  logic [7:0] outdir;
  logic [1:0] dir_chg;
  logic [5:0] dbg_sel;

  int edge_cnt = 0;
  int n_cmp    = 0;
  int n_err    = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  joy_dir_filter #(
    .NUM_PLAYERS(2),
    .DEBOUNCE   (4),
    .CNT_W      (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .mode   (mode),
    .indir  (indir),
    .outdir (outdir),
    .dir_chg(dir_chg),
    .dbg_sel(dbg_sel)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Driver tasks (all called right after a negedge)
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] v);
    indir = v;
  endtask

  task automatic expect_evt(input int dly, input logic [1:0] chg, input logic [7:0] od);
    logic [EW-1:0] e;
    e = {16'(edge_cnt + dly), chg, od};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (dir_chg != 2'b00) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_chg: edge %0d outdir=%h dir_chg=%b, no change expected",
                   edge_cnt, outdir, dir_chg);
        end else begin
          mon_e = exp_q.pop_front();
          if (outdir !== mon_e[7:0] || dir_chg !== mon_e[9:8] || edge_cnt[15:0] !== mon_e[25:10]) begin
            n_err++;
            $display("FAIL event: got edge %0d outdir=%h dir_chg=%b, expected edge %0d outdir=%h dir_chg=%b",
                     edge_cnt, outdir, dir_chg, mon_e[25:10], mon_e[7:0], mon_e[9:8]);
          end
        end
      end else if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        if (int'(mon_e[25:10]) <= edge_cnt) begin
          void'(exp_q.pop_front());
          n_cmp++;
          n_err++;
          $display("FAIL missed_event: at edge %0d saw outdir=%h dir_chg=%b, expected outdir=%h dir_chg=%b",
                   edge_cnt, outdir, dir_chg, mon_e[7:0], mon_e[9:8]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    mode  = 2'd0;
    indir = 8'hFF;

    // Reset holds everything at zero
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outdir", 32'(outdir), 32'h0);
      check("reset_chg", 32'(dir_chg), 32'h0);
    end
    check("reset_sel", 32'(dbg_sel), 32'h0);
    reset = 1'b0;
    indir = 8'h00;
    @(negedge clk);
    check("post_reset_outdir", 32'(outdir), 32'h0);
    check("post_reset_chg", 32'(dir_chg), 32'h0);

    // Mode 0: debounce latency and glitch rejection
    cycles(3);
    apply(8'h01); expect_evt(7, 2'b01, 8'h01); cycles(12);
    apply(8'h03); cycles(3); apply(8'h01); cycles(12);        // 3-clk glitch
    apply(8'h03); expect_evt(7, 2'b01, 8'h03); cycles(4);     // 4-clk pulse passes
    apply(8'h01); expect_evt(7, 2'b01, 8'h01); cycles(12);
    apply(8'h00); expect_evt(7, 2'b01, 8'h00); cycles(12);

    // Mode 1: last-pressed
    mode = 2'd1; cycles(3);
    apply(8'h01); expect_evt(7, 2'b01, 8'h01); cycles(12);
    apply(8'h09); expect_evt(7, 2'b01, 8'h08); cycles(12);
    apply(8'h01); expect_evt(7, 2'b01, 8'h01); cycles(12);
    apply(8'h00); expect_evt(7, 2'b01, 8'h00); cycles(12);
    apply(8'h06); expect_evt(7, 2'b01, 8'h04); cycles(12);
    apply(8'h00); expect_evt(7, 2'b01, 8'h00); cycles(12);

    // Mode 2: first-held
    mode = 2'd2; cycles(3);
    apply(8'h02); expect_evt(7, 2'b01, 8'h02); cycles(12);
    apply(8'h0A); cycles(12);                                 // up ignored
    apply(8'h08); expect_evt(7, 2'b01, 8'h08); cycles(12);
    apply(8'h00); expect_evt(7, 2'b01, 8'h00); cycles(12);

    // Mode 3: SOCD cancel on player 1
    mode = 2'd3; cycles(3);
    apply(8'hC0); cycles(12);                                 // up+down cancel
    apply(8'hB0); expect_evt(7, 2'b10, 8'h80); cycles(12);
    apply(8'hA0); expect_evt(7, 2'b10, 8'hA0); cycles(12);

    // Mode switches clear all players for one edge
    mode = 2'd1; expect_evt(1, 2'b10, 8'h00); cycles(3);
    apply(8'hA8); expect_evt(7, 2'b01, 8'h08); cycles(12);
    mode = 2'd3; expect_evt(1, 2'b01, 8'h00); expect_evt(2, 2'b11, 8'hA8); cycles(12);
    apply(8'h00); expect_evt(7, 2'b11, 8'h00); cycles(12);

    // Every expected event must have been consumed
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("final_outdir", 32'(outdir), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/joy_dir_filter.md
Name: joy_dir_filter

Overview:
Parametrised per-player joystick direction conditioner, placed between the joystick merge logic (USB/DB9/DB15 selection) and the arcade core inputs. It replaces the single-mode one-direction mask with four things:
- a synchroniser;
- a per-bit debounce;
- a runtime-selectable direction policy: pass-through, 4-way last-pressed, 4-way first-held, or 8-way with opposing-direction cancel;
- a per-player change strobe.

Parameters:
NUM_PLAYERS, 2, number of independent 4-bit direction channels.
DEBOUNCE, 4, number of consecutive ce samples of a new level needed before the debounced bit follows it; 0 bypasses debounce.
CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE.

Ports:
clk  in  1  system clock (clk_sys domain).
reset  in  1  synchronous, active-high reset.
ce  in  1  debounce sample enable (e.g. 1 kHz tick); tie high for per-clock sampling.
mode  in  2  0=pass, 1=4-way last-pressed, 2=4-way first-held, 3=8-way SOCD cancel.
indir  in  4*NUM_PLAYERS  raw directions, asynchronous. Per player p, bits [4p+3:4p] = {up,down,left,right}, active high.
outdir  out  4*NUM_PLAYERS  filtered directions, same bit order, registered.
dir_chg  out  NUM_PLAYERS  one-clk pulse when that player's outdir changes.

Behaviour:
- Reset (synchronous, clk edge with reset=1) clears the following; all outputs read 0 from the first edge after reset is asserted.
  - sync registers, debounced bits, debounce counters;
  - selection state (forced to IDLE);
  - outdir, dir_chg.
- Synchroniser: 2 flops per indir bit, clocked every clk and not gated by ce.
- Debounce, per bit, evaluated only on cycles with ce=1:
  - sync bit == debounced bit: counter <= 0.
  - otherwise the counter increments; on the DEBOUNCE-th consecutive differing sample, the debounced bit takes the new level and the counter clears.
  - A single agreeing sample restarts the count.
  - DEBOUNCE=0: debounced bit = sync output, no counter.
- Selection state per player, for modes 1/2: IDLE, or SEL(d) with d one of up/down/left/right.
  - Updated every clk from the debounced bits (db).
  - "Rise" = bit of db that was 0 on the previous clk.
  - Fixed priority when choosing among several bits: up > down > left > right.
- Mode 0: outdir <= db.
- Mode 1, last-pressed:
  - any rise → SEL(highest-priority rising bit), even when already in SEL;
  - else if in SEL(d) and d released → SEL(highest-priority held bit), or IDLE if none held;
  - outdir <= one-hot of SEL(d), or 0 in IDLE.
- Mode 2, first-held:
  - IDLE with any bit held → SEL(highest-priority held bit);
  - SEL(d) ignores all other presses while d is held;
  - when d is released, reselect the highest-priority held bit, else IDLE.
  - Output encoding as mode 1.
- Mode 3: outdir <= db, except:
  - up and down both held → both outputs 0;
  - left and right both held → both outputs 0.
- Mode change (mode differs from its previous-clk value): all players go to IDLE and outdir <= 0 on that edge; normal evaluation resumes on the next clk.
- Latency, raw change to outdir, with ce=1 continuously: 3+DEBOUNCE clk edges (DEBOUNCE=0 → 3 edges).
- dir_chg[p] is asserted on the same edge outdir[p] takes its new value, for exactly one clk. A pulse caused by a mode-change clear is included.
- Players are fully independent; no cross-player interaction.
- Counter/selection state holds while ce=0; the output logic still runs every clk.

Test Plan:
1. Reset: reset=1 for 2 clks with indir=8'hFF → outdir=0 and dir_chg=0 throughout and on the first clk after release.
2. Debounce, DEBOUNCE=4, ce=1, mode 0:
   - P0 right held → outdir[0]=1 exactly 7 edges later, dir_chg[0] pulses one clk.
   - A 3-clk glitch on left → outdir never changes.
3. Mode 1, P0:
   - hold right → 4'b0001;
   - add up → 4'b1000;
   - release up with right still held → 4'b0001;
   - release all → 4'b0000;
   - simultaneous rise of down+left → 4'b0100.
4. Mode 2, P0:
   - hold left → 4'b0010;
   - add up → stays 4'b0010;
   - release left → 4'b1000.
5. Mode 3, P1:
   - indir[7:4]=4'b1100 → outdir[7:4]=4'b0000;
   - 4'b1011 → 4'b1000;
   - 4'b1010 → 4'b1010.
6. Mode switch 1→3 while P0 holds up: outdir[3:0]=0 on the switch edge with a dir_chg[0] pulse, then 4'b1000 one edge later. P1 state unaffected except for its own clear.
